// File: rtl/serial_receiver.sv
// rtl/serial_receiver.sv - 8N1 serial receiver with synchronizer, framing check and receive FIFO
module serial_receiver #(
   parameter int comm_clk_frequency = 50_000_000,
   parameter int baud_rate          = 115200,
   parameter int FIFO_DEPTH         = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       RxD,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic [4:0] rx_count,
   output logic       framing_error,
   output logic       overrun
);

   localparam int DIV   = comm_clk_frequency / baud_rate;
   localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [4:0]       DEPTH_C  = 5'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t           state_q, state_d;
   logic             sync1_q, sync2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             push_q, push_d;
   logic             ferr_q, ferr_d;
   logic             ovr_q, ovr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [4:0]       count_q, count_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic [7:0]       mem_q [FIFO_DEPTH];

   logic             pop, full, wr_en;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      push_d    = 1'b0;
      ferr_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!sync2_q) begin
               cnt_d   = CNT_HALF;
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == '0) begin
               if (!sync2_q) begin
                  cnt_d     = CNT_FULL;
                  bit_idx_d = 3'd0;
                  state_d   = S_DATA;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_DATA: begin
            if (cnt_q == '0) begin
               shift_d   = {sync2_q, shift_q[7:1]};
               cnt_d     = CNT_FULL;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_STOP: begin
            if (cnt_q == '0) begin
               if (sync2_q) begin
                  push_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_BREAK: begin
            if (sync2_q) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A push into a full FIFO only lands when the same cycle frees a slot.
   always_comb begin
      pop      = valid_q && rx_ready;
      full     = (count_q == DEPTH_C);
      wr_en    = push_q && (!full || pop);
      ovr_d    = ovr_q || (push_q && full && !pop);
      wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + 5'(wr_en) - 5'(pop);
      valid_d  = (count_d != 5'd0);
      data_d   = data_q;
      if (count_d != 5'd0) begin
         // New byte bypasses the memory when it becomes the head this cycle.
         data_d = (wr_en && (wr_ptr_q == rd_ptr_d)) ? shift_q : mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= shift_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         cnt_q     <= '0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         push_q    <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= 5'd0;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= RxD;
         sync2_q   <= sync1_q;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         push_q    <= push_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
      end
   end

   assign rx_data       = data_q;
   assign rx_valid      = valid_q;
   assign rx_count      = count_q;
   assign framing_error = ferr_q;
   assign overrun       = ovr_q;

endmodule

// File: tb/tb_serial_receiver.sv
// tb/tb_serial_receiver.sv - scoreboard bench for serial_receiver at DIV=16, FIFO_DEPTH=4
module tb_serial_receiver;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       RxD = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [4:0] rx_count;
   logic       framing_error;
   logic       overrun;

   int checks = 0;
   int errors = 0;
   int valid_cnt = 0;
   int ferr_cnt = 0;
   logic [7:0] exp_q [$];

   serial_receiver #(
      .comm_clk_frequency(1600),
      .baud_rate(100),
      .FIFO_DEPTH(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .RxD(RxD),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .rx_count(rx_count),
      .framing_error(framing_error),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Scoreboard: every accepted byte must match the oldest expectation.
   always @(negedge clk) begin
      if (!reset) begin
         if (rx_valid) valid_cnt++;
         if (framing_error) ferr_cnt++;
         if (rx_valid && rx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_unexpected: got byte %02h, required no byte", rx_data);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if (rx_data !== e) begin
                  errors++;
                  $display("FAIL scoreboard_data: got %02h, required %02h", rx_data, e);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // One 8N1 frame, 16 cycles per bit; optional rx_ready pulse at cycle ready_at, early exit at abort_at.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int ready_at, input int abort_at);
      for (int k = 0; k < 160; k++) begin
         tick();
         if (k == abort_at) return;
         if (k < 16) RxD = 1'b0;
         else if (k < 144) RxD = b[(k - 16) / 16];
         else RxD = stop_bit;
         if (ready_at >= 0) begin
            if (k == ready_at) rx_ready = 1'b1;
            else if (k == ready_at + 1) rx_ready = 1'b0;
         end
      end
      tick();
      RxD = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      RxD = 1'b1;
      rx_ready = 1'b0;
      idle(3);
      @(negedge clk);
      checks++;
      if (rx_valid !== 1'b0 || rx_count !== 5'd0 || rx_data !== 8'h00 ||
          framing_error !== 1'b0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got valid=%b count=%0d data=%02h ferr=%b ovr=%b, required 0/0/00/0/0",
                  rx_valid, rx_count, rx_data, framing_error, overrun);
      end
      tick();
      reset = 1'b0;
      idle(4);
   endtask

   task automatic test_single_byte();
      rx_ready = 1'b1;
      valid_cnt = 0;
      ferr_cnt = 0;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, -1, -1);
      idle(10);
      @(negedge clk);
      checks++;
      if (valid_cnt !== 1) begin
         errors++;
         $display("FAIL single_valid_cycles: got %0d, required 1", valid_cnt);
      end
      checks++;
      if (ferr_cnt !== 0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL single_flags: got ferr pulses=%0d ovr=%b, required 0/0", ferr_cnt, overrun);
      end
      checks++;
      if (exp_q.size() !== 0 || rx_count !== 5'd0) begin
         errors++;
         $display("FAIL single_drained: got pending=%0d count=%0d, required 0/0", exp_q.size(), rx_count);
      end
   endtask

   task automatic test_false_start();
      rx_ready = 1'b1;
      valid_cnt = 0;
      ferr_cnt = 0;
      tick();
      RxD = 1'b0;
      idle(6);
      RxD = 1'b1;
      idle(30);
      @(negedge clk);
      checks++;
      if (valid_cnt !== 0 || rx_count !== 5'd0 || ferr_cnt !== 0) begin
         errors++;
         $display("FAIL false_start: got valid cycles=%0d count=%0d ferr=%0d, required 0/0/0",
                  valid_cnt, rx_count, ferr_cnt);
      end
      exp_q.push_back(8'hC3);
      send_frame(8'hC3, 1'b1, -1, -1);
      idle(10);
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL after_glitch_rx: got pending=%0d, required 0", exp_q.size());
      end
   endtask

   task automatic test_framing_error();
      rx_ready = 1'b1;
      valid_cnt = 0;
      ferr_cnt = 0;
      send_frame(8'h3C, 1'b0, -1, -1);
      idle(10);
      @(negedge clk);
      checks++;
      if (ferr_cnt !== 1) begin
         errors++;
         $display("FAIL framing_pulse: got %0d cycles, required 1", ferr_cnt);
      end
      checks++;
      if (rx_count !== 5'd0 || valid_cnt !== 0) begin
         errors++;
         $display("FAIL framing_discard: got count=%0d valid cycles=%0d, required 0/0", rx_count, valid_cnt);
      end
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, -1, -1);
      idle(10);
      checks++;
      if (exp_q.size() !== 0 || ferr_cnt !== 1) begin
         errors++;
         $display("FAIL framing_recover: got pending=%0d ferr=%0d, required 0/1", exp_q.size(), ferr_cnt);
      end
   endtask

   task automatic test_overrun();
      rx_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         exp_q.push_back(8'(i));
         send_frame(8'(i), 1'b1, -1, -1);
         idle(3);
      end
      @(negedge clk);
      checks++;
      if (rx_count !== 5'd4 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL fill_four: got count=%0d ovr=%b, required 4/0", rx_count, overrun);
      end
      send_frame(8'h05, 1'b1, -1, -1);
      idle(3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (rx_count !== 5'd4 || overrun !== 1'b1 || rx_valid !== 1'b1 || rx_data !== 8'h01) begin
            errors++;
            $display("FAIL overrun_hold: got count=%0d ovr=%b valid=%b data=%02h, required 4/1/1/01",
                     rx_count, overrun, rx_valid, rx_data);
         end
      end
      tick();
      rx_ready = 1'b1;
      idle(20);
      @(negedge clk);
      checks++;
      if (exp_q.size() !== 0 || rx_count !== 5'd0 || overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_drain: got pending=%0d count=%0d ovr=%b, required 0/0/1",
                  exp_q.size(), rx_count, overrun);
      end
   endtask

   task automatic test_reset_mid_frame();
      rx_ready = 1'b0;
      send_frame(8'h77, 1'b1, -1, -1);
      idle(3);
      @(negedge clk);
      checks++;
      if (rx_valid !== 1'b1 || overrun !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_state: got valid=%b ovr=%b, required 1/1", rx_valid, overrun);
      end
      send_frame(8'hFF, 1'b1, -1, 88);
      reset = 1'b1;
      #1;
      checks++;
      if (rx_valid !== 1'b0 || rx_count !== 5'd0 || rx_data !== 8'h00 ||
          framing_error !== 1'b0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got valid=%b count=%0d data=%02h ferr=%b ovr=%b, required 0/0/00/0/0",
                  rx_valid, rx_count, rx_data, framing_error, overrun);
      end
      RxD = 1'b1;
      idle(3);
      reset = 1'b0;
      idle(4);
      rx_ready = 1'b1;
      valid_cnt = 0;
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1, -1, -1);
      idle(10);
      checks++;
      if (exp_q.size() !== 0 || valid_cnt !== 1 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_rx: got pending=%0d valid cycles=%0d ovr=%b, required 0/1/0",
                  exp_q.size(), valid_cnt, overrun);
      end
   endtask

   task automatic test_push_pop_full();
      rx_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(8'h21 + 8'(i));
         send_frame(8'h21 + 8'(i), 1'b1, -1, -1);
         idle(3);
      end
      @(negedge clk);
      checks++;
      if (rx_count !== 5'd4) begin
         errors++;
         $display("FAIL full_before: got count=%0d, required 4", rx_count);
      end
      exp_q.push_back(8'h25);
      // Stop bit is sampled after cycle 155 of the frame; the push lands one cycle later.
      send_frame(8'h25, 1'b1, 155, -1);
      @(negedge clk);
      checks++;
      if (rx_count !== 5'd4 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL full_push_pop: got count=%0d ovr=%b, required 4/0", rx_count, overrun);
      end
      checks++;
      if (exp_q.size() !== 4 || rx_data !== 8'h22) begin
         errors++;
         $display("FAIL full_head: got pending=%0d data=%02h, required 4/22", exp_q.size(), rx_data);
      end
      tick();
      rx_ready = 1'b1;
      idle(20);
      @(negedge clk);
      checks++;
      if (exp_q.size() !== 0 || rx_count !== 5'd0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL full_drain: got pending=%0d count=%0d ovr=%b, required 0/0/0",
                  exp_q.size(), rx_count, overrun);
      end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_false_start();
      test_framing_error();
      test_overrun();
      test_reset_mid_frame();
      test_push_pop_full();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_receiver.md
SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 SHALL have parameter comm_clk_frequency, default 50_000_000, clk frequency in Hz.
REQ-002 SHALL have parameter baud_rate, default 115200, serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, receive buffer entries, power of two, 2..16.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port RxD  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rx_data  output  8  byte at FIFO head.
REQ-008 SHALL have port rx_valid  output  1  FIFO non-empty; rx_data is meaningful.
REQ-009 SHALL have port rx_ready  input  1  consumer accepts rx_data this cycle.
REQ-010 SHALL have port rx_count  output  5  current FIFO occupancy, 0..FIFO_DEPTH.
REQ-011 SHALL have port framing_error  output  1  one-cycle pulse on bad stop bit.
REQ-012 SHALL have port overrun  output  1  sticky; a byte was lost to a full FIFO.

Function
REQ-013 SHALL pass RxD through a 2-flop synchronizer; all decisions use the synchronized value, giving 2 cycles input latency.
REQ-014 SHALL use DIV = comm_clk_frequency / baud_rate (integer division, DIV >= 4) as bit period in clk cycles; baud counter width sized to DIV-1.
REQ-015 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-016 IDLE: on synchronized RxD = 0, load counter with DIV/2 - 1, go START.
REQ-017 START: on counter expiry sample line; 0 -> reload DIV-1, bit index 0, go DATA; 1 -> false start, go IDLE, nothing recorded.
REQ-018 DATA: at each counter expiry sample line into shift register LSB first, reload DIV-1; after bit index 7 sampled go STOP.
REQ-019 STOP: at counter expiry sample line; 1 -> push byte to FIFO, go IDLE same cycle; 0 -> pulse framing_error one cycle, discard byte, go BREAK.
REQ-020 BREAK: remain until synchronized RxD = 1, then go IDLE.
REQ-021 Push SHALL occur in the cycle after the stop-bit sample; rx_valid SHALL rise on the following cycle when FIFO was empty.
REQ-022 Pop SHALL occur on each cycle with rx_valid = 1 and rx_ready = 1; rx_data SHALL then show the next entry the following cycle; rx_ready with rx_valid = 0 has no effect.
REQ-023 rx_data and rx_valid SHALL be registered and stable while rx_valid = 1 and rx_ready = 0.
REQ-024 Push when FIFO full and no pop SHALL drop the incoming byte and set overrun; FIFO contents unchanged.
REQ-025 Simultaneous push and pop SHALL both complete, count unchanged, including when full (no overrun).
REQ-026 Read/write pointers SHALL wrap modulo FIFO_DEPTH; rx_count SHALL track occupancy exactly.
REQ-027 overrun SHALL stay 1 until reset.

Reset
REQ-028 Reset assertion SHALL immediately force state IDLE, synchronizer flops to 1, counters and pointers to 0, rx_count 0, rx_valid 0, rx_data 8'h00, framing_error 0, overrun 0.
REQ-029 Reset mid-frame SHALL abandon the frame; after release the receiver SHALL wait for a new falling edge (a line already low enters START normally).

Verification (bench: comm_clk_frequency=1600, baud_rate=100, DIV=16, FIFO_DEPTH=4)
REQ-030 Send 8'hA5, 8N1, rx_ready=1 -> rx_valid high one cycle with rx_data=8'hA5, framing_error 0, overrun 0.
REQ-031 Low glitch of 6 cycles on idle line -> false start, no push, state back to IDLE, rx_count 0.
REQ-032 Send 8'h3C with stop bit driven 0, then line high -> framing_error one pulse, rx_count 0, next frame 8'h11 received correctly.
REQ-033 rx_ready=0, send 8'h01..8'h05 -> rx_count 4, overrun 1; then drain -> 8'h01,8'h02,8'h03,8'h04 in order, rx_count 0.
REQ-034 FIFO full, rx_ready=1 asserted exactly in push cycle -> count stays 4, overrun stays 0, new byte appears last in drain order.
REQ-035 Assert reset during data bit 4 of 8'hFF -> all outputs at reset values immediately; subsequent 8'h5A received intact.
